// File: rtl/ex_op_sequencer_pkg.sv
// ex_seq_pkg: shared enums, opcodes and control bundle for the execute-stage sequencer
package ex_seq_pkg;
  typedef enum logic [3:0] {
    ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
    XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9
  } alu_op_e;
  typedef enum logic [2:0] {
    RESULT = 3'd0, LINK = 3'd1, TARGET = 3'd2, CMP = 3'd3, ADDR = 3'd4, ILLEGAL = 3'd7
  } res_kind_e;
  typedef enum logic [1:0] {IDLE, PH1, PH2} seq_state_e;
  typedef struct packed {
    logic zero;
    logic pc;
    logic imm;
    logic c4;
    alu_op_e op;
  } ctrl_t;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  // funct3 to ALU op for register/immediate arithmetic; alt selects SUB/SRA
  function automatic alu_op_e aluMap(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  aluMap = alt ? SUB : ADD;
      3'b001:  aluMap = SLL;
      3'b010:  aluMap = SLT;
      3'b011:  aluMap = SLTU;
      3'b100:  aluMap = XOR;
      3'b101:  aluMap = alt ? SRA : SRL;
      3'b110:  aluMap = OR;
      default: aluMap = AND;
    endcase
  endfunction
endpackage

// File: rtl/ex_op_sequencer_if.sv
// ex_op_sequencer_if: decoded-op handshake, ALU selects and tagged result slot
interface ex_op_sequencer_if;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       setDataZero;
  logic       pc_operand;
  logic       immSel;
  logic       addConstant4;
  logic [3:0] alu_op;
  logic       res_valid;
  logic [2:0] res_kind;
  logic       res_ready;
  modport master (
    output flush, in_valid, opcode, funct3, funct7b5, res_ready,
    input  in_ready, setDataZero, pc_operand, immSel, addConstant4, alu_op, res_valid, res_kind
  );
  modport slave (
    input  flush, in_valid, opcode, funct3, funct7b5, res_ready,
    output in_ready, setDataZero, pc_operand, immSel, addConstant4, alu_op, res_valid, res_kind
  );
endinterface

// File: rtl/ex_op_sequencer_decode.sv
// ex_op_decode: per-phase operand selects, ALU op and slot tag for one instruction
module ex_op_decode
  import ex_seq_pkg::*;
#(
  parameter bit BRANCH_2PH = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       f7b5,
  input  logic       phase,
  output ctrl_t      ctrl,
  output res_kind_e  kind,
  output logic       twoPhase
);
  // phase=0 is PH1, phase=1 is PH2; unknown opcodes fall through as ILLEGAL with no selects
  always_comb begin
    ctrl = '0;
    kind = ILLEGAL;
    twoPhase = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl.op = aluMap(f3, f7b5);
        kind = RESULT;
      end
      OPC_OPIMM: begin
        ctrl.imm = 1'b1;
        ctrl.op = aluMap(f3, f3 == 3'b101 && f7b5);
        kind = RESULT;
      end
      OPC_LUI: begin
        ctrl.zero = 1'b1;
        ctrl.imm = 1'b1;
        kind = RESULT;
      end
      OPC_AUIPC: begin
        ctrl.pc = 1'b1;
        ctrl.imm = 1'b1;
        kind = RESULT;
      end
      OPC_LOAD, OPC_STORE: begin
        ctrl.imm = 1'b1;
        kind = ADDR;
      end
      OPC_JAL: begin
        twoPhase = 1'b1;
        ctrl.pc = 1'b1;
        ctrl.c4 = !phase;
        ctrl.imm = phase;
        kind = phase ? TARGET : LINK;
      end
      OPC_JALR: begin
        twoPhase = 1'b1;
        ctrl.pc = !phase;
        ctrl.c4 = !phase;
        ctrl.imm = phase;
        kind = phase ? TARGET : LINK;
      end
      OPC_BRANCH: begin
        twoPhase = BRANCH_2PH;
        ctrl.pc = phase;
        ctrl.imm = phase;
        ctrl.op = phase ? ADD : (f3[2] ? (f3[1] ? SLTU : SLT) : SUB);
        kind = phase ? TARGET : CMP;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/ex_op_sequencer.sv
// ex_op_sequencer: time-shares the single ALU over one or two tagged phases per op
module ex_op_sequencer
  import ex_seq_pkg::*;
#(
  parameter bit BRANCH_2PH = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  ex_op_sequencer_if.slave  bus
);
  seq_state_e state;
  logic [6:0] opReg;
  logic [2:0] f3Reg;
  logic       f7Reg;
  ctrl_t      ctrl;
  res_kind_e  kind;
  logic       twoPhase;
  logic       busy;
  logic       lastPhase;
  logic       accept;

  ex_op_decode #(.BRANCH_2PH(BRANCH_2PH)) u_decode (
    .opcode   (opReg),
    .f3       (f3Reg),
    .f7b5     (f7Reg),
    .phase    (state == PH2),
    .ctrl     (ctrl),
    .kind     (kind),
    .twoPhase (twoPhase)
  );

  assign busy      = state != IDLE;
  assign lastPhase = state == PH2 || (state == PH1 && !twoPhase);
  assign accept    = bus.in_valid && bus.in_ready;

  assign bus.in_ready     = !bus.flush && (!busy || (lastPhase && bus.res_ready));
  assign bus.res_valid    = busy && !bus.flush;
  assign bus.setDataZero  = busy && ctrl.zero;
  assign bus.pc_operand   = busy && ctrl.pc;
  assign bus.immSel       = busy && ctrl.imm;
  assign bus.addConstant4 = busy && ctrl.c4;
  assign bus.alu_op       = busy ? ctrl.op : ADD;
  assign bus.res_kind     = busy ? kind : RESULT;

  // phase FSM and instruction register; flush beats accept, accept beats phase advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opReg <= '0;
      f3Reg <= '0;
      f7Reg <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else if (accept) begin
      state <= PH1;
      opReg <= bus.opcode;
      f3Reg <= bus.funct3;
      f7Reg <= bus.funct7b5;
    end else if (busy && bus.res_ready) begin
      state <= (state == PH1 && twoPhase) ? PH2 : IDLE;
    end
  end
endmodule
